seg_scroll: RTL and testbench
=============================

SEG_SCROLL -- requirements
Module: seg_scroll

Interface
REQ-001 Parameter DEPTH, 16, character buffer capacity; power of two, 8..32.
REQ-002 Parameter TICK_DIV, 12_500_000, clock cycles per scroll step; >= 2.
REQ-003 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port wr_valid  in  1  character write request.
REQ-006 Port wr_char  in  5  character code: 0-15 hex digit, 16 blank, 17 minus sign, 18-31 blank.
REQ-007 Port wr_ready  out  1  buffer can accept a character this cycle.
REQ-008 Port clear  in  1  synchronous buffer clear.
REQ-009 Port scroll_en  in  1  enables scrolling when more than 8 characters are held.
REQ-010 Port dp_mask  in  8  decimal-point request per digit, bit k drives digit k.
REQ-011 Port en  out  8  digit enable per digit, 1 = digit in use; feeds the downstream digit scanner.
REQ-012 Port display  out  [7:0][7:0]  segment pattern per digit; digit 0 is rightmost.
REQ-013 Port count  out  $clog2(DEPTH)+1  number of characters held.

Function
REQ-014 Segment byte encoding: bit0..bit6 = segments a..g, bit7 = dp; active-low, 0 = lit.
REQ-015 Fixed glyphs (dp off): 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90, A=0x88, b=0x83, C=0xC6, d=0xA1, E=0x86, F=0x8E, minus=0xBF, blank=0xFF.
REQ-016 display[k] bit7 = ~dp_mask[k] for every enabled digit; disabled digits output 0xFF, with dp forced off.
REQ-017 wr_ready = (count < DEPTH) && !clear; combinational.
REQ-018 Write accepted when wr_valid && wr_ready: wr_char is stored at index count, count increments by 1; the newest character has the highest index.
REQ-019 wr_valid while wr_ready = 0: no state change; the character is dropped, not queued.
REQ-020 clear = 1: count, pos and tick go to 0; clear takes priority over a same-cycle write.
REQ-021 Static mode (count <= 8, or scroll_en = 0): characters right-aligned; digit k shows char[count-1-k] for k < count; en[k] = (k < count); with scroll_en = 0 and count > 8, the 8 newest characters are shown.
REQ-022 Scroll mode (count > 8 and scroll_en = 1): window offset pos in 0..count-1; digit 7-j shows char[(pos+j) mod count] for j = 0..7; en = 0xFF.
REQ-023 Tick counter: runs 0..TICK_DIV-1 only in scroll mode; at TICK_DIV-1 it wraps to 0 and pos advances by 1, wrapping from count-1 to 0.
REQ-024 Leaving scroll mode (scroll_en falls, or clear) sets tick and pos to 0; re-entry starts at pos 0 with a full TICK_DIV interval.
REQ-025 A write during scroll mode keeps pos and tick; the new character joins the circular sequence at its end.
REQ-026 en and display are registered: any state change at edge N is visible on the outputs after edge N+1, which is a fixed one-cycle latency.
REQ-027 dp_mask changes are also visible after one registered cycle.
REQ-028 Buffer storage needs no reset; positions at or above count never reach the outputs.

Reset
REQ-029 While rst = 0: count = 0, pos = 0, tick = 0, en = 0x00, all display bytes = 0xFF.
REQ-030 Reset asserted mid-scroll or mid-write: state is abandoned immediately; the first write after release lands at index 0.
REQ-031 After release, wr_ready = ~clear.

Verification
REQ-032 Reset, write codes 1,2,3 on consecutive cycles, dp_mask = 0 -> after the last write, en = 0x07, display[2..0] = 0xF9, 0xA4, 0xB0, display[7..3] = 0xFF.
REQ-033 Write DEPTH characters, then hold wr_valid -> wr_ready = 0, count stays DEPTH, further characters dropped; clear together with wr_valid -> count = 0, en = 0x00 one cycle later.
REQ-034 TICK_DIV = 4, write 10 characters 0..9, scroll_en = 1 -> display[7] = 0xC0 initially; 0xF9 after 4 cycles; after 40 cycles it is back to 0xC0, because pos wraps at 10.
REQ-035 Same setup, drop scroll_en mid-interval -> next output: en = 0xFF, digits show the 8 newest (2..9, digit 0 = 0x90); re-raise -> first step exactly TICK_DIV cycles later.
REQ-036 Write codes 16 and 17, dp_mask = 0x01 -> display[0] = 0x3F (minus with dp lit), display[1] = 0xFF, en = 0x03.
REQ-037 Assert rst during scroll mode with count = 12 -> outputs go to en = 0x00 and display = 0xFF without a clock edge; count = 0.

Source files
------------

// File: rtl/seg_scroll.sv
// Scrolling eight-digit seven-segment text buffer.
// Holds up to DEPTH character codes and presents them as active-low segment
// bytes: right-aligned when they fit (or scrolling is off), otherwise as a
// circular window that advances one character every TICK_DIV clocks.
module seg_scroll #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [4:0]              wr_char,
    output logic                    wr_ready,
    input  logic                    clear,
    input  logic                    scroll_en,
    input  logic [7:0]              dp_mask,
    output logic [7:0]              en,
    output logic [7:0][7:0]         display,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TICK_DIV);

    logic [4:0]      char_q [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   pos_q;
    logic [TW-1:0]   tick_q;

    logic            scroll_mode;
    logic            wr_accept;
    logic            tick_wrap;

    logic [7:0]      en_d;
    logic [7:0][7:0] display_d;
    logic [CW:0]     sum;
    logic [AW-1:0]   idx;

    assign count       = count_q;
    assign scroll_mode = scroll_en && (count_q > CW'(8));
    assign wr_ready    = (count_q < CW'(DEPTH)) && !clear;
    assign wr_accept   = wr_valid && wr_ready;
    assign tick_wrap   = (tick_q == TW'(TICK_DIV - 1));

    // Segment bits a..g (active-low) for a character code; dp is added later.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            5'd17:   seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Character storage; unreset because entries at or above count are never shown.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            char_q[count_q[AW-1:0]] <= wr_char;
        end
    end

    // Fill level, scroll position and step timer.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pos_q   <= '0;
            tick_q  <= '0;
        end else if (clear) begin
            count_q <= '0;
            pos_q   <= '0;
            tick_q  <= '0;
        end else begin
            if (wr_accept) begin
                count_q <= count_q + CW'(1);
            end
            if (!scroll_mode) begin
                // Re-entry always starts at the first character with a full interval.
                tick_q <= '0;
                pos_q  <= '0;
            end else if (tick_wrap) begin
                tick_q <= '0;
                pos_q  <= (pos_q == count_q - CW'(1)) ? '0 : pos_q + CW'(1);
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    // Map buffer contents onto the eight digits for the current mode.
    always_comb begin
        en_d      = '0;
        display_d = '1;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < 8; k++) begin
            if (scroll_mode) begin
                // pos < count and count > 8, so one subtraction is a full modulo.
                sum = {1'b0, pos_q} + (CW + 1)'(7 - k);
                if (sum >= {1'b0, count_q}) begin
                    sum = sum - {1'b0, count_q};
                end
                idx     = AW'(sum);
                en_d[k] = 1'b1;
            end else if (CW'(k) < count_q) begin
                idx     = AW'(count_q - CW'(1) - CW'(k));
                en_d[k] = 1'b1;
            end
            if (en_d[k]) begin
                display_d[k] = {~dp_mask[k], glyph(char_q[idx])};
            end
        end
    end

    // Registered digit outputs: one cycle behind the state they depict.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            en      <= '0;
            display <= '1;
        end else begin
            en      <= en_d;
            display <= display_d;
        end
    end

endmodule

// File: tb/tb_seg_scroll.sv
// Directed bench for seg_scroll: static layout, glyphs, full/clear, scrolling, reset.
module tb_seg_scroll;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TICK_DIV = 4;

    logic            clock = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic [4:0]      wr_char;
    logic            wr_ready;
    logic            clear;
    logic            scroll_en;
    logic [7:0]      dp_mask;
    logic [7:0]      en;
    logic [7:0][7:0] display;
    logic [4:0]      count;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] ALL_OFF = {8{8'hFF}};

    seg_scroll #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .clear     (clear),
        .scroll_en (scroll_en),
        .dp_mask   (dp_mask),
        .en        (en),
        .display   (display),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One character per cycle; consecutive calls write on consecutive edges.
    task automatic write_char(input logic [4:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid  = 1'b0;
        wr_char   = '0;
        clear     = 1'b0;
        scroll_en = 1'b0;
        dp_mask   = '0;
        @(negedge clock);
        rst = 1'b0;
        #2;
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        total++; if (en !== 8'h00) $display("FAIL reset_en: got %h expected %h", en, 8'h00); else passed++;
        total++; if (display !== ALL_OFF) $display("FAIL reset_display: got %h expected %h", display, ALL_OFF); else passed++;
        total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
        @(negedge clock);
        rst = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", wr_ready); else passed++;
        clear = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b0) $display("FAIL reset_ready_clear: got %b expected 0", wr_ready); else passed++;
        clear = 1'b0;
    endtask

    task automatic test_static();
        do_reset();
        write_char(5'd1);
        write_char(5'd2);
        write_char(5'd3);
        total++; if (count !== 5'd3) $display("FAIL static_count: got %0d expected 3", count); else passed++;
        total++; if (en !== 8'h03) $display("FAIL static_latency_en: got %h expected %h", en, 8'h03); else passed++;
        cycles(1);
        total++; if (en !== 8'h07) $display("FAIL static_en: got %h expected %h", en, 8'h07); else passed++;
        total++; if (display[2:0] !== {8'hF9, 8'hA4, 8'hB0})
            $display("FAIL static_low: got %h expected %h", display[2:0], {8'hF9, 8'hA4, 8'hB0}); else passed++;
        total++; if (display[7:3] !== {5{8'hFF}})
            $display("FAIL static_high: got %h expected %h", display[7:3], {5{8'hFF}}); else passed++;
    endtask

    task automatic test_glyphs();
        do_reset();
        dp_mask = 8'h01;
        write_char(5'd16);
        write_char(5'd17);
        cycles(1);
        total++; if (display[0] !== 8'h3F) $display("FAIL glyph_minus_dp: got %h expected %h", display[0], 8'h3F); else passed++;
        total++; if (display[1] !== 8'hFF) $display("FAIL glyph_blank: got %h expected %h", display[1], 8'hFF); else passed++;
        total++; if (en !== 8'h03) $display("FAIL glyph_en: got %h expected %h", en, 8'h03); else passed++;
        dp_mask = 8'hFF;
        cycles(1);
        total++; if (display[1] !== 8'h7F) $display("FAIL glyph_dp_enabled: got %h expected %h", display[1], 8'h7F); else passed++;
        total++; if (display[2] !== 8'hFF) $display("FAIL glyph_dp_disabled: got %h expected %h", display[2], 8'hFF); else passed++;
        do_reset();
        write_char(5'd10); write_char(5'd11); write_char(5'd12); write_char(5'd13);
        write_char(5'd14); write_char(5'd15); write_char(5'd20); write_char(5'd8);
        cycles(1);
        total++; if (display !== {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hFF, 8'h80})
            $display("FAIL glyph_hex: got %h expected %h", display,
                     {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hFF, 8'h80}); else passed++;
    endtask

    task automatic test_full_clear();
        do_reset();
        for (int i = 0; i < 16; i++) write_char(5'(i));
        total++; if (count !== 5'd16) $display("FAIL full_count: got %0d expected 16", count); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", wr_ready); else passed++;
        wr_valid = 1'b1;
        wr_char  = 5'd5;
        cycles(3);
        total++; if (count !== 5'd16) $display("FAIL full_drop_count: got %0d expected 16", count); else passed++;
        total++; if (display[0] !== 8'h8E) $display("FAIL full_newest: got %h expected %h", display[0], 8'h8E); else passed++;
        total++; if (display[7] !== 8'h80) $display("FAIL full_oldest_shown: got %h expected %h", display[7], 8'h80); else passed++;
        clear = 1'b1;
        cycles(1);
        total++; if (count !== 5'd0) $display("FAIL clear_count: got %0d expected 0", count); else passed++;
        total++; if (en !== 8'hFF) $display("FAIL clear_latency_en: got %h expected %h", en, 8'hFF); else passed++;
        cycles(1);
        total++; if (en !== 8'h00) $display("FAIL clear_en: got %h expected %h", en, 8'h00); else passed++;
        total++; if (display !== ALL_OFF) $display("FAIL clear_display: got %h expected %h", display, ALL_OFF); else passed++;
        clear    = 1'b0;
        wr_valid = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b1) $display("FAIL clear_ready: got %b expected 1", wr_ready); else passed++;
        @(negedge clock);
        write_char(5'd4);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 5'd7;
        #1;
        total++; if (wr_ready !== 1'b0) $display("FAIL clear_blocks_ready: got %b expected 0", wr_ready); else passed++;
        @(negedge clock);
        total++; if (count !== 5'd0) $display("FAIL clear_priority: got %0d expected 0", count); else passed++;
        clear    = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic test_scroll();
        do_reset();
        for (int i = 0; i < 10; i++) write_char(5'(i));
        scroll_en = 1'b1;
        cycles(1);
        total++; if (display[7] !== 8'hC0) $display("FAIL scroll_start_d7: got %h expected %h", display[7], 8'hC0); else passed++;
        total++; if (display[0] !== 8'hF8) $display("FAIL scroll_start_d0: got %h expected %h", display[0], 8'hF8); else passed++;
        total++; if (en !== 8'hFF) $display("FAIL scroll_en_all: got %h expected %h", en, 8'hFF); else passed++;
        cycles(3);
        total++; if (display[7] !== 8'hC0) $display("FAIL scroll_before_step: got %h expected %h", display[7], 8'hC0); else passed++;
        cycles(1);
        total++; if (display[7] !== 8'hF9) $display("FAIL scroll_step1: got %h expected %h", display[7], 8'hF9); else passed++;
        cycles(35);
        total++; if (display[7] !== 8'h90) $display("FAIL scroll_pos9_d7: got %h expected %h", display[7], 8'h90); else passed++;
        total++; if (display[6] !== 8'hC0) $display("FAIL scroll_pos9_wrap: got %h expected %h", display[6], 8'hC0); else passed++;
        cycles(1);
        total++; if (display[7] !== 8'hC0) $display("FAIL scroll_wrap: got %h expected %h", display[7], 8'hC0); else passed++;
        scroll_en = 1'b0;
    endtask

    task automatic test_scroll_drop();
        do_reset();
        for (int i = 0; i < 10; i++) write_char(5'(i));
        scroll_en = 1'b1;
        cycles(6);
        total++; if (display[7] !== 8'hF9) $display("FAIL drop_pre: got %h expected %h", display[7], 8'hF9); else passed++;
        scroll_en = 1'b0;
        cycles(1);
        total++; if (en !== 8'hFF) $display("FAIL drop_en: got %h expected %h", en, 8'hFF); else passed++;
        total++; if (display[0] !== 8'h90) $display("FAIL drop_d0: got %h expected %h", display[0], 8'h90); else passed++;
        total++; if (display[7] !== 8'hA4) $display("FAIL drop_d7: got %h expected %h", display[7], 8'hA4); else passed++;
        cycles(2);
        scroll_en = 1'b1;
        cycles(4);
        total++; if (display[7] !== 8'hC0) $display("FAIL reentry_hold: got %h expected %h", display[7], 8'hC0); else passed++;
        cycles(1);
        total++; if (display[7] !== 8'hF9) $display("FAIL reentry_step: got %h expected %h", display[7], 8'hF9); else passed++;
        scroll_en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 12; i++) write_char(5'(i));
        scroll_en = 1'b1;
        cycles(5);
        #2;
        rst = 1'b0;
        #1;
        total++; if (en !== 8'h00) $display("FAIL async_en: got %h expected %h", en, 8'h00); else passed++;
        total++; if (display !== ALL_OFF) $display("FAIL async_display: got %h expected %h", display, ALL_OFF); else passed++;
        total++; if (count !== 5'd0) $display("FAIL async_count: got %0d expected 0", count); else passed++;
        @(negedge clock);
        rst       = 1'b1;
        scroll_en = 1'b0;
        write_char(5'd3);
        cycles(1);
        total++; if (count !== 5'd1) $display("FAIL async_after_count: got %0d expected 1", count); else passed++;
        total++; if (display[0] !== 8'hB0) $display("FAIL async_after_d0: got %h expected %h", display[0], 8'hB0); else passed++;
        total++; if (en !== 8'h01) $display("FAIL async_after_en: got %h expected %h", en, 8'h01); else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_char   = '0;
        clear     = 1'b0;
        scroll_en = 1'b0;
        dp_mask   = '0;
        #1;
        test_reset();
        test_static();
        test_glyphs();
        test_full_clear();
        test_scroll();
        test_scroll_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
